// File: rtl/reg_cmd_sequencer.sv
// Command sequencer for the 4-bit shift/count register block.
// Define REG_CMD_SAT_EN to make INC/DEC saturate instead of wrap.
module reg_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] reg_out,
    output logic             cl,
    output logic             ld,
    output logic             inc,
    output logic             dec,
    output logic             sr,
    output logic             ir,
    output logic             sl,
    output logic             il,
    output logic [WIDTH-1:0] reg_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_CLR = 3'b001;
    localparam logic [2:0] OP_LD  = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SETTLE,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rsp_q;
    logic             sat_hi;
    logic             sat_lo;

`ifdef REG_CMD_SAT_EN
    assign sat_hi = &reg_out;
    assign sat_lo = ~|reg_out;
`else
    assign sat_hi = 1'b0;
    assign sat_lo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_NOP;
            data_q <= '0;
            cnt_q  <= '0;
            rsp_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        data_q <= cmd_data;
                        cnt_q  <= cmd_cnt;
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                SETTLE: begin
                    rsp_q <= reg_out;
                end
                RESP: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // Pulses come straight from state so reset drops them at once.
    always_comb begin
        cl        = 1'b0;
        ld        = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        sr        = 1'b0;
        ir        = 1'b0;
        sl        = 1'b0;
        il        = 1'b0;
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        if (state == EXEC) begin
            unique case (op_q)
                OP_NOP: begin
                end
                OP_CLR: begin
                    cl = 1'b1;
                end
                OP_LD: begin
                    ld = 1'b1;
                end
                OP_INC: begin
                    inc = ~sat_hi;
                end
                OP_DEC: begin
                    dec = ~sat_lo;
                end
                OP_SHR: begin
                    sr = 1'b1;
                    ir = data_q[0];
                end
                OP_SHL: begin
                    sl = 1'b1;
                    il = data_q[0];
                end
                OP_ROR: begin
                    sr = 1'b1;
                    ir = reg_out[0];
                end
            endcase
        end
    end

    assign reg_in   = data_q;
    assign rsp_data = rsp_q;

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed bench for reg_cmd_sequencer driving a behavioural
// model of the 4-bit shift/count register.
module tb_reg_cmd_sequencer;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_CLR = 3'b001;
    localparam logic [2:0] OP_LD  = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

`ifdef REG_CMD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [1:0] cmd_cnt;
    logic [3:0] reg_out;
    logic       cl, ld, inc, dec, sr, ir, sl, il;
    logic [3:0] reg_in;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [3:0] rm = 4'b0000;

    int n_pass = 0;
    int n_total = 0;

    reg_cmd_sequencer #(.WIDTH(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .reg_out   (reg_out),
        .cl        (cl),
        .ld        (ld),
        .inc       (inc),
        .dec       (dec),
        .sr        (sr),
        .ir        (ir),
        .sl        (sl),
        .il        (il),
        .reg_in    (reg_in),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The controlled register: not reset, one action per edge.
    always @(posedge clk) begin
        if (cl) rm <= 4'b0000;
        else if (ld) rm <= reg_in;
        else if (inc) rm <= rm + 4'd1;
        else if (dec) rm <= rm - 4'd1;
        else if (sr) rm <= {ir, rm[3:1]};
        else if (sl) rm <= {rm[2:0], il};
    end
    assign reg_out = rm;

    wire [7:0] ctrl = {cl, ld, inc, dec, sr, ir, sl, il};

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        logic [1:0] cnt;
        logic [3:0] exp;
        int         hold;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    function automatic logic [7:0] exp_ctrl(input logic [2:0] op,
                                            input logic [3:0] d,
                                            input logic [3:0] r);
        logic [7:0] e;
        e = 8'h00;
        case (op)
            OP_CLR: e = 8'b1000_0000;
            OP_LD:  e = 8'b0100_0000;
            OP_INC: e = (SAT && r == 4'hF) ? 8'h00 : 8'b0010_0000;
            OP_DEC: e = (SAT && r == 4'h0) ? 8'h00 : 8'b0001_0000;
            OP_SHR: e = {5'b00001, d[0], 2'b00};
            OP_SHL: e = {7'b0000001, d[0]};
            OP_ROR: e = {5'b00001, r[0], 2'b00};
            default: e = 8'h00;
        endcase
        return e;
    endfunction

    // Called at a negedge with the sequencer idle.
    task automatic do_cmd(input logic [2:0] op, input logic [3:0] d,
                          input logic [1:0] c, input logic [3:0] exp,
                          input int hold);
        chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_op    = op;
        cmd_data  = d;
        cmd_cnt   = c;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i <= int'(c); i++) begin
            @(negedge clk);
            chk("exec_ctrl", {20'd0, ctrl, reg_in, cmd_ready, rsp_valid},
                {20'd0, exp_ctrl(op, d, rm), d, 1'b0, 1'b0});
        end
        @(negedge clk);
        chk("settle", {22'd0, ctrl, rsp_valid, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("resp", {22'd0, rsp_valid, rsp_data, cmd_ready},
            {22'd0, 1'b1, exp, 1'b0});
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                cmd_op    = OP_CLR;
                cmd_data  = 4'h0;
                cmd_cnt   = 2'd0;
                cmd_valid = 1'b1;
            end
            @(negedge clk);
            chk("resp_hold", {18'd0, rsp_valid, rsp_data, cmd_ready, ctrl},
                {18'd0, 1'b1, exp, 1'b0, 8'h00});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("back_idle", {26'd0, rsp_valid, cmd_ready, rsp_data},
            {26'd0, 1'b0, 1'b1, exp});
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = 4'h0;
        cmd_cnt   = 2'd0;
        rsp_ready = 1'b1;

        vt[0]  = '{OP_LD,  4'b1010, 2'd0, 4'hA, 0};
        vt[1]  = '{OP_LD,  4'b1110, 2'd0, 4'hE, 0};
        vt[2]  = '{OP_INC, 4'b0000, 2'd3, SAT ? 4'hF : 4'h2, 0};
        vt[3]  = '{OP_LD,  4'b0001, 2'd0, 4'h1, 0};
        vt[4]  = '{OP_SHL, 4'b0001, 2'd1, 4'h7, 0};
        vt[5]  = '{OP_LD,  4'b0011, 2'd0, 4'h3, 5};
        vt[6]  = '{OP_ROR, 4'b0000, 2'd0, 4'h9, 0};
        vt[7]  = '{OP_DEC, 4'b0000, 2'd1, 4'h7, 0};
        vt[8]  = '{OP_LD,  4'b0000, 2'd0, 4'h0, 0};
        vt[9]  = '{OP_DEC, 4'b0000, 2'd0, SAT ? 4'h0 : 4'hF, 0};
        vt[10] = '{OP_LD,  4'b1111, 2'd0, 4'hF, 0};
        vt[11] = '{OP_INC, 4'b0000, 2'd0, SAT ? 4'hF : 4'h0, 0};
        vt[12] = '{OP_LD,  4'b1100, 2'd0, 4'hC, 0};
        vt[13] = '{OP_SHR, 4'b0001, 2'd1, 4'hF, 0};
        vt[14] = '{OP_CLR, 4'b0000, 2'd0, 4'h0, 0};
        vt[15] = '{OP_LD,  4'b0110, 2'd0, 4'h6, 0};
        vt[16] = '{OP_NOP, 4'b1001, 2'd2, 4'h6, 0};
        vt[17] = '{OP_ROR, 4'b0000, 2'd3, 4'h6, 0};
        vt[18] = '{OP_SHR, 4'b0000, 2'd0, 4'h3, 0};

        #12;
        chk("reset_state",
            {16'd0, cmd_ready, ctrl, reg_in, rsp_valid, rsp_data[2:0]},
            {16'd0, 1'b1, 8'h00, 4'h0, 1'b0, 3'd0});
        chk("reset_rsp_data", {28'd0, rsp_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i]) begin
            do_cmd(vt[i].op, vt[i].data, vt[i].cnt, vt[i].exp, vt[i].hold);
        end

        // Reset in the second EXEC cycle of a CLR aborts it.
        cmd_op    = OP_CLR;
        cmd_data  = 4'h0;
        cmd_cnt   = 2'd3;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_cycle1", {24'd0, ctrl}, 32'h80);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_now", {22'd0, ctrl, cmd_ready, rsp_valid},
            {22'd0, 8'h00, 1'b1, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || ctrl != 8'h00) seen = 1'b1;
        end
        chk("abort_no_rsp", {31'd0, seen}, 32'd0);

        do_cmd(OP_LD, 4'b0101, 2'd0, 4'h5, 0);
        do_cmd(OP_ROR, 4'b0000, 2'd0, 4'hA, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
